mem_arb: RTL and testbench

- Arbitrates one single-ported main memory between the instruction-fetch path (PC side) and the data path (LD/ST/LDR, driven by ctl's moe/mwr).
- Sequences each access as a request/ready transaction and returns read data through a registered acknowledge.
- Applies round-robin priority when both ports are pending.
- Aborts with an error pulse if memory fails to respond within a bounded time; the error feeds the ILLOP/exception path.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_timer.sv | 35 +++
 rtl/mem_arb.sv | 133 +++++++++++++
 tb/tb_mem_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the main-memory arbiter.
// Imported by mem_arb and its timeout timer.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2
  } state_t;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable access-timeout counter.
// tc flags the last allowed wait cycle; TIMEOUT = 0 never fires.
module mem_arb_timer #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic          ld,
  input  logic [TW-1:0] ld_val,
  output logic          tc
);

  localparam logic [TW-1:0] LAST =
    TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (en) begin
      count <= count + TW'(1);
    end
  end

  assign tc = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one memory port
// between instruction fetch and data load/store.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          busy
);

  state_t state;
  logic   last_gnt;
  logic   i_elig;
  logic   d_elig;
  logic   pick_i;
  logic   tmr_clr;
  logic   tmr_en;
  logic   tc;
  logic   done;

  // a req still high during its own ack cycle is the old one
  assign i_elig  = i_req && !i_ack;
  assign d_elig  = d_req && !d_ack;
  assign pick_i  = i_elig && (!d_elig || last_gnt == GNT_DATA);
  assign tmr_clr = (state == ST_IDLE);
  assign tmr_en  = (state != ST_IDLE);
  assign done    = m_ready || tc;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .ld      (1'b0),
    .ld_val  ({TW{1'b0}}),
    .tc      (tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      last_gnt <= GNT_DATA;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_rdata  <= '0;
      i_ack    <= 1'b0;
      i_err    <= 1'b0;
      d_rdata  <= '0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_i) begin
            state    <= ST_IBUSY;
            last_gnt <= GNT_FETCH;
            m_addr   <= i_addr;
            m_we     <= 1'b0;
            m_req    <= 1'b1;
            busy     <= 1'b1;
          end else if (d_elig) begin
            state    <= ST_DBUSY;
            last_gnt <= GNT_DATA;
            m_addr   <= d_addr;
            m_we     <= d_we;
            m_wdata  <= d_wdata;
            m_req    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_IBUSY: begin
          if (done) begin
            state   <= ST_IDLE;
            m_req   <= 1'b0;
            busy    <= 1'b0;
            i_ack   <= 1'b1;
            i_err   <= !m_ready;
            i_rdata <= m_ready ? m_rdata : '0;
          end
        end
        ST_DBUSY: begin
          if (done) begin
            state   <= ST_IDLE;
            m_req   <= 1'b0;
            busy    <= 1'b0;
            d_ack   <= 1'b1;
            d_err   <= !m_ready;
            d_rdata <= m_ready ? m_rdata : '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          m_req <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: vector table, hand sequences and random traffic
// for mem_arb, scored against a transaction-level model.
module tb_mem_arb;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  mem_arb #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (TO),
    .TW      (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .i_err   (i_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .d_err   (d_err),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .busy    (busy)
  );

  typedef struct {
    string       name;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          pre_en;
    logic [31:0] pre;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  int lat = 0;
  int wcnt = 0;
  bit rand_lat = 1'b0;

  function automatic logic [31:0] dflt(logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    if (refm.exists(a)) return refm[a];
    return dflt(a);
  endfunction

  function automatic logic [159:0] outs();
    return {25'd0, m_req, m_we, busy, i_ack, i_err, d_ack, d_err,
            m_addr, m_wdata, i_rdata, d_rdata};
  endfunction

  function automatic vec_t mk(string n, bit d, bit w,
                              logic [31:0] a, logic [31:0] wd,
                              int l, bit pe, logic [31:0] p,
                              logic [31:0] e, bit ee);
    vec_t v;
    v.name = n; v.is_d = d; v.we = w; v.addr = a; v.wdata = wd;
    v.lat = l; v.pre_en = pe; v.pre = p; v.exp_rd = e; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // memory responder: m_ready lat cycles after m_req is first seen
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (m_ready) begin
      m_ready = 1'b0;
      m_rdata = $urandom;
      wcnt = 0;
    end else if (m_req) begin
      if (rand_lat && wcnt == 0) lat = $urandom_range(0, 5);
      if (wcnt == lat) begin
        m_ready = 1'b1;
        m_rdata = mem_rd(m_addr);
        if (m_we) mem[m_addr] = m_wdata;
      end else begin
        wcnt++;
        m_rdata = $urandom;
      end
    end else begin
      wcnt = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    m_ready = 1'b0;
    wcnt = 0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic run_one(input vec_t v);
    int k;
    int exp_k;
    logic [31:0] a0, w0, rd;
    logic we0, bad, oth, ak, er;
    lat = v.lat;
    if (v.pre_en) mem[v.addr] = v.pre;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    tick();
    chk($sformatf("%s_mreq", v.name), m_req, 1);
    chk($sformatf("%s_maddr", v.name), m_addr, v.addr);
    chk($sformatf("%s_mwe", v.name), m_we, v.is_d & v.we);
    if (v.is_d && v.we)
      chk($sformatf("%s_mwdata", v.name), m_wdata, v.wdata);
    a0 = m_addr; w0 = m_wdata; we0 = m_we;
    bad = 1'b0; oth = 1'b0; k = 0;
    ak = v.is_d ? d_ack : i_ack;
    while (!ak && k < 20) begin
      if (m_req && (m_addr !== a0 || m_wdata !== w0 || m_we !== we0))
        bad = 1'b1;
      oth = oth | (v.is_d ? i_ack : d_ack);
      tick();
      k++;
      ak = v.is_d ? d_ack : i_ack;
    end
    exp_k = (v.lat < TO ? v.lat : TO - 1) + 1;
    chk($sformatf("%s_stable", v.name), bad, 0);
    chk($sformatf("%s_acklat", v.name), k, exp_k);
    er = v.is_d ? d_err : i_err;
    rd = v.is_d ? d_rdata : i_rdata;
    chk($sformatf("%s_err", v.name), er, v.exp_err);
    if (!(v.is_d && v.we))
      chk($sformatf("%s_rdata", v.name), rd, v.exp_rd);
    oth = oth | (v.is_d ? i_ack : d_ack);
    chk($sformatf("%s_otherack", v.name), oth, 0);
    tick();
    chk($sformatf("%s_pulse", v.name),
        {i_ack, i_err, d_ack, d_err, m_req, busy}, 0);
    if (v.is_d) d_req = 1'b0;
    else i_req = 1'b0;
    tick();
  endtask

  task automatic set_req(input int q, input bit on,
                         input logic [31:0] a, input bit w,
                         input logic [31:0] wd);
    if (q == 0) begin
      i_req = on; i_addr = a;
    end else begin
      d_req = on; d_we = w; d_addr = a; d_wdata = wd;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vt[8];
    logic        acc;
    logic [3:0]  order;
    int          ng;
    logic        prev;
    bit          pend[2], gnt[2], drop[2], wer[2], crd[2], eerr[2];
    logic [31:0] ad[2], wd[2], erd[2];
    int          age[2], oth[2];
    int          gi, ngr;
    logic        ak, er;
    logic [31:0] rd;

    vt[0] = mk("fetch40", 0, 0, 32'h40, 0, 3, 1,
               32'hDEADBEEF, 32'hDEADBEEF, 0);
    vt[1] = mk("store200", 1, 1, 32'h200, 32'h12345678, 2, 0,
               0, 0, 0);
    vt[2] = mk("load200", 1, 0, 32'h200, 0, 0, 0,
               0, 32'h12345678, 0);
    vt[3] = mk("ld_tmo", 1, 0, 32'h300, 0, 50, 1,
               32'hCAFEF00D, 32'h0, 1);
    vt[4] = mk("f_final", 0, 0, 32'h44, 0, 3, 1,
               32'h55, 32'h55, 0);
    vt[5] = mk("f_tmo", 0, 0, 32'h48, 0, 50, 1,
               32'h11112222, 32'h0, 1);
    vt[6] = mk("ld304", 1, 0, 32'h304, 0, 1, 1,
               32'h0BADC0DE, 32'h0BADC0DE, 0);
    vt[7] = mk("st_tmo", 1, 1, 32'h308, 32'h77, 50, 0,
               0, 0, 1);

    #2 reset_n = 1'b0;
    tick();
    tick();
    chk("reset_outs", outs(), 0);
    reset_n = 1'b1;
    tick();

    for (int n = 0; n < 8; n++) run_one(vt[n]);

    // reset in the middle of a store
    lat = 50;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h240; d_wdata = 32'hA5A5A5A5;
    tick();
    tick();
    chk("rst_mid_busy", {m_req, busy}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", outs(), 0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      acc = acc | i_ack | i_err | d_ack | d_err | m_req | busy;
    end
    chk("rst_silent", acc, 0);
    run_one(mk("f100", 0, 0, 32'h100, 0, 0, 1,
               32'h0F0F0F0F, 32'h0F0F0F0F, 0));

    // both ports held: grants must alternate starting with fetch
    do_reset();
    lat = 1;
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180;
    order = '0; ng = 0; prev = 1'b0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      tick();
      if (m_req && !prev) begin
        order = {order[2:0], m_addr == 32'h180};
        ng++;
      end
      prev = m_req;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("cont_grants", ng, 4);
    chk("cont_order", order, 4'b0101);
    for (int c = 0; c < 20 && (busy || m_req); c++) tick();
    tick();
    tick();

    // random traffic against the transaction model
    do_reset();
    rand_lat = 1'b1;
    for (int q = 0; q < 2; q++) begin
      pend[q] = 0; gnt[q] = 0; drop[q] = 0; wer[q] = 0;
      crd[q] = 0; eerr[q] = 0; ad[q] = '0; wd[q] = '0;
      erd[q] = '0; age[q] = 0; oth[q] = 0;
    end
    prev = 1'b0; ngr = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (m_req && !prev) begin
        gi = (m_addr[11:8] == 4'hC) ? 1 : 0;
        chk("rnd_gnt_pend", {pend[gi], gnt[gi]}, 2'b10);
        chk("rnd_gnt_addr", m_addr, ad[gi]);
        chk("rnd_gnt_we", m_we, (gi == 1) && wer[gi]);
        if (gi == 1 && wer[gi]) chk("rnd_gnt_wdata", m_wdata, wd[gi]);
        gnt[gi] = 1;
        eerr[gi] = (lat >= TO);
        crd[gi] = !(gi == 1 && wer[gi]);
        if (eerr[gi]) erd[gi] = '0;
        else if (!crd[gi]) refm[ad[gi]] = wd[gi];
        else erd[gi] = ref_rd(ad[gi]);
        if (pend[1-gi] && !gnt[1-gi]) begin
          oth[1-gi]++;
          chk("rnd_fair", oth[1-gi] <= 1, 1);
        end
        ngr++;
      end
      prev = m_req;
      for (int q = 0; q < 2; q++) begin
        ak = (q == 1) ? d_ack : i_ack;
        er = (q == 1) ? d_err : i_err;
        rd = (q == 1) ? d_rdata : i_rdata;
        if (drop[q]) begin
          chk("rnd_ack_once", ak, 0);
          drop[q] = 0;
          set_req(q, 0, ad[q], wer[q], wd[q]);
        end else if (ak) begin
          chk("rnd_ack_gnt", gnt[q], 1);
          chk("rnd_err", er, eerr[q]);
          if (crd[q]) chk("rnd_rdata", rd, erd[q]);
          pend[q] = 0; gnt[q] = 0; drop[q] = 1;
          crd[q] = 0; eerr[q] = 0;
        end else if (pend[q]) begin
          age[q]++;
          if (age[q] == 40) begin
            total_cnt++;
            $display("FAIL rnd_stall: port %0d waited %0d cycles, required < 40",
                     q, age[q]);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          pend[q] = 1; age[q] = 0; oth[q] = 0;
          ad[q] = ((q == 1) ? 32'hC00 : 32'h800) +
                  32'($urandom_range(0, 15) * 4);
          wer[q] = (q == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          wd[q] = $urandom;
          set_req(q, 1, ad[q], wer[q], wd[q]);
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    rand_lat = 1'b0;
    for (int c = 0; c < 20 && (busy || m_req); c++) tick();
    chk("rnd_traffic", ngr > 50, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
